// File: rtl/wb_pkg.sv
// Shared Wishbone B4 tag encodings and FSM state for the burst-capable BRAM slave.
package wb_pkg;

    typedef enum logic [2:0] {
        CLASSIC = 3'b000,
        CONST   = 3'b001,
        INCR    = 3'b010,
        EOB     = 3'b111
    } cti_t;

    typedef enum logic [1:0] {
        LINEAR = 2'b00,
        WRAP4  = 2'b01,
        WRAP8  = 2'b10,
        WRAP16 = 2'b11
    } bte_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/wb_burst_addr.sv
// Next word address for an incrementing burst: only the wrap-window bits step,
// so a linear burst rolls over at the top of memory and wrap bursts stay in their block.
module wb_burst_addr
    import wb_pkg::*;
#(
    parameter int unsigned AW = 11
) (
    input  logic [AW-1:0] addr_i,
    input  bte_t          bte_i,
    input  logic          inc_i,
    output logic [AW-1:0] next_o
);

    logic [AW-1:0] plus_c;
    logic [AW-1:0] mask_c;

    always_comb begin
        plus_c = addr_i + AW'(1);
        unique case (bte_i)
            WRAP4:   mask_c = AW'(3);
            WRAP8:   mask_c = AW'(7);
            WRAP16:  mask_c = AW'(15);
            default: mask_c = '1;
        endcase
        next_o = inc_i ? ((addr_i & ~mask_c) | (plus_c & mask_c)) : addr_i;
    end

endmodule

// File: rtl/wb_bram_burst.sv
// Wishbone B4 pipelined-burst slave in front of a byte-writable single-port block RAM,
// sustaining one word per cycle on constant and incrementing bursts.
module wb_bram_burst
    import wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned MEM_ADR_WIDTH = 11,
    parameter int unsigned ADR_WIDTH     = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cyc,
    input  logic                    stb,
    input  logic                    we,
    input  logic [ADR_WIDTH-1:0]    adr,
    input  logic [DATA_WIDTH/8-1:0] sel,
    input  logic [2:0]              cti,
    input  logic [1:0]              bte,
    input  logic [DATA_WIDTH-1:0]   dat_ms,
    output logic [DATA_WIDTH-1:0]   dat_sm,
    output logic                    ack,
    output logic                    err,
    output logic                    rty
);

    localparam int unsigned SEL_W = DATA_WIDTH / 8;
    localparam int unsigned LSB   = $clog2(SEL_W);
    localparam int unsigned DEPTH = 1 << MEM_ADR_WIDTH;

    state_t                     state_q, state_d;
    logic                       ack_q, ack_d;
    logic                       err_q, err_d;
    logic [MEM_ADR_WIDTH-1:0]   addr_q, addr_d;
    logic [MEM_ADR_WIDTH-1:0]   next_addr_c;
    logic [DATA_WIDTH-1:0]      rd_q;
    logic [DATA_WIDTH-1:0]      mem_q [DEPTH];
    logic                       req_c;
    logic                       oor_c;
    logic                       inc_c;
    logic                       wr_en_c;
    logic                       unused_c;

    assign req_c    = cyc & stb;
    assign oor_c    = |adr[ADR_WIDTH-1:LSB+MEM_ADR_WIDTH];
    assign inc_c    = (cti == INCR);
    assign unused_c = ^adr[LSB-1:0];

    // A reset edge must never commit the beat in flight.
    assign wr_en_c  = rst_n & ack_q & we & req_c;

    wb_burst_addr #(
        .AW     (MEM_ADR_WIDTH)
    ) u_burst_addr (
        .addr_i (addr_q),
        .bte_i  (bte_t'(bte)),
        .inc_i  (inc_c),
        .next_o (next_addr_c)
    );

    // addr_d doubles as the RAM read address, so the next beat is fetched one cycle early.
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (req_c) begin
                    state_d = ACTIVE;
                    addr_d  = adr[LSB +: MEM_ADR_WIDTH];
                    err_d   = oor_c;
                    ack_d   = ~oor_c;
                end
            end
            ACTIVE: begin
                state_d = IDLE;
                if (ack_q && req_c) begin
                    case (cti)
                        CONST, INCR: begin
                            state_d = ACTIVE;
                            ack_d   = 1'b1;
                            addr_d  = next_addr_c;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
        end
    end

    // Array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        for (int b = 0; b < int'(SEL_W); b++) begin
            if (wr_en_c && sel[b]) begin
                mem_q[addr_q][b*8 +: 8] <= dat_ms[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem_q[addr_d];
        end
    end

    assign dat_sm = rd_q;
    assign ack    = ack_q;
    assign err    = err_q;
    assign rty    = 1'b0;

endmodule

// File: tb/tb_wb_bram_burst.sv
// Directed plus randomized Wishbone transfers checked against an array-based memory model.
module tb_wb_bram_burst;

    localparam int unsigned DEPTH = 2048;

    logic        clk;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        ack, err, rty;

    int          vectors;
    int          miscompares;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] last_rd;

    wb_bram_burst dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cyc    (cyc),
        .stb    (stb),
        .we     (we),
        .adr    (adr),
        .sel    (sel),
        .cti    (cti),
        .bte    (bte),
        .dat_ms (dat_ms),
        .dat_sm (dat_sm),
        .ack    (ack),
        .err    (err),
        .rty    (rty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned ref_next(input int unsigned w, input int unsigned bt);
        int unsigned n;
        case (bt)
            0:       return (w + 1) % DEPTH;
            1:       n = 4;
            2:       n = 8;
            default: n = 16;
        endcase
        return (w / n) * n + (w + 1) % n;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // mode: 0 classic, 1 constant burst, 2 incrementing burst, 3 reserved cti.
    // dmode: 0 random data, 1 data = beat+1, 2 data = d0.
    // abort_kind: 1 reset during abort_beat, 2 strobe dropped instead of abort_beat.
    task automatic xfer(input bit wr, input logic [31:0] a, input int n, input int mode,
                        input logic [1:0] bt, input logic [3:0] sl, input int dmode,
                        input logic [31:0] d0, input int abort_beat, input int abort_kind);
        int unsigned w;
        logic [31:0] d;
        logic [2:0]  c;
        w = (a >> 2) % DEPTH;
        for (int i = 0; i < n; i++) begin
            if (i == abort_beat && abort_kind == 2) begin
                stb = 1'b0;
                @(posedge clk); #1;
                chk("drop_ack", 32'(ack), 32'd0);
                cyc = 1'b0;
                return;
            end
            d = (dmode == 0) ? $urandom : (dmode == 1) ? 32'(i + 1) : d0;
            if (mode == 0)      c = 3'b000;
            else if (mode == 3) c = 3'(3 + $urandom_range(3));
            else if (i == n-1)  c = 3'b111;
            else                c = (mode == 1) ? 3'b001 : 3'b010;
            cyc = 1'b1; stb = 1'b1; we = wr; adr = a; sel = sl;
            cti = c; bte = bt; dat_ms = d;
            if (i == 0) begin
                chk("ack_idle", 32'(ack), 32'd0);
                @(posedge clk); #1;
            end
            chk("ack", 32'(ack), 32'd1);
            chk("err", 32'(err), 32'd0);
            if (!wr) begin
                chk("rdata", dat_sm, ref_mem[w]);
                last_rd = dat_sm;
            end
            if (i == abort_beat && abort_kind == 1) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                chk("rst_ack", 32'(ack), 32'd0);
                chk("rst_dat", dat_sm, 32'd0);
                rst_n = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
                return;
            end
            @(posedge clk);
            if (wr) ref_mem[w] = merge(ref_mem[w], d, sl);
            #1;
            if (mode == 2) w = ref_next(w, 32'(bt));
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        chk("ack_end", 32'(ack), 32'd0);
    endtask

    task automatic xfer_err(input bit wr, input logic [31:0] a);
        cyc = 1'b1; stb = 1'b1; we = wr; adr = a; sel = 4'hF; cti = 3'b000; dat_ms = $urandom;
        @(posedge clk); #1;
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_noack", 32'(ack), 32'd0);
        @(posedge clk); #1;
        chk("err_end", 32'(err), 32'd0);
        chk("err_end_ack", 32'(ack), 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0;
        cti = '0; bte = '0; dat_ms = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_dat", dat_sm, 32'd0);
        chk("rty", 32'(rty), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill every word with one linear burst that rolls over the top of memory.
        xfer(1, 32'((DEPTH - 8) * 4), DEPTH, 2, 2'b00, 4'hF, 0, 0, -1, 0);

        xfer(1, 32'h10, 1, 0, 2'b00, 4'hF, 2, 32'hDEADBEEF, -1, 0);
        xfer(0, 32'h10, 1, 0, 2'b00, 4'hF, 0, 0, -1, 0);
        chk("classic_rd", last_rd, 32'hDEADBEEF);
        xfer(1, 32'h10, 1, 0, 2'b00, 4'b0010, 2, 32'h0000AB00, -1, 0);
        xfer(0, 32'h10, 1, 0, 2'b00, 4'hF, 0, 0, -1, 0);
        chk("byte_rd", last_rd, 32'hDEADABEF);

        xfer(1, 32'h40, 8, 2, 2'b00, 4'hF, 1, 0, -1, 0);
        xfer(0, 32'h40, 8, 2, 2'b00, 4'hF, 0, 0, -1, 0);
        chk("incr_last", last_rd, 32'd8);

        xfer(0, 32'h18, 4, 2, 2'b01, 4'hF, 0, 0, -1, 0);
        xfer(0, 32'h3D4, 8, 2, 2'b10, 4'hF, 0, 0, -1, 0);
        xfer(0, 32'h7E8, 16, 2, 2'b11, 4'hF, 0, 0, -1, 0);
        xfer(0, 32'((DEPTH - 2) * 4), 4, 2, 2'b00, 4'hF, 0, 0, -1, 0);

        xfer(1, 32'h0, 1, 0, 2'b00, 4'hF, 2, 32'h13579BDF, -1, 0);
        xfer_err(0, 32'h2000);
        xfer_err(1, 32'h2000);
        xfer(0, 32'h0, 1, 0, 2'b00, 4'hF, 0, 0, -1, 0);
        chk("err_nowrite", last_rd, 32'h13579BDF);

        xfer(0, 32'h84, 1, 3, 2'b00, 4'hF, 0, 0, -1, 0);
        xfer(1, 32'h90, 5, 1, 2'b00, 4'hF, 0, 0, -1, 0);
        xfer(0, 32'h90, 3, 1, 2'b00, 4'hF, 0, 0, -1, 0);

        xfer(1, 32'h100, 8, 2, 2'b00, 4'hF, 0, 0, 3, 2);
        xfer(0, 32'h100, 8, 2, 2'b00, 4'hF, 0, 0, -1, 0);

        xfer(1, 32'h200, 8, 2, 2'b00, 4'hF, 1, 0, 2, 1);
        xfer(0, 32'h200, 8, 2, 2'b00, 4'hF, 0, 0, -1, 0);

        for (int k = 0; k < 40; k++) begin
            int m;
            int n;
            m = int'($urandom_range(3));
            n = (m == 0 || m == 3) ? 1 : int'($urandom_range(16, 1));
            xfer(1'($urandom_range(1)), 32'($urandom_range(DEPTH - 1)) << 2, n, m,
                 2'($urandom_range(3)), 4'($urandom_range(15)), 0, 0, -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
